// File: rtl/display_scroller_pkg.sv
// display_scroller_pkg
// Types and constants shared by the display scroller and its prescaler.
//   state_e      : LOAD (collecting characters) / SCROLL (rotating text)
//   ASCII_SPACE  : code shown on any digit without a message character
package display_scroller_pkg;

  typedef enum logic {
    LOAD   = 1'b0,
    SCROLL = 1'b1
  } state_e;

  localparam logic [7:0] ASCII_SPACE = 8'h20;

  // Number of display digits driven by the scroller.
  localparam int NUM_DIGITS = 4;

endpackage : display_scroller_pkg

// File: rtl/display_scroller_tick_gen.sv
// tick_gen
// Free-running prescaler that pulses tick for one cycle every TICK_DIV
// cycles. While clr is high the count is held at zero, so the first tick
// after clr is released arrives TICK_DIV cycles later.
// Ports:
//   clk  : system clock, rising edge
//   rstn : synchronous active-low reset
//   clr  : hold counter at zero
//   tick : one-cycle pulse, high while the count sits at TICK_DIV-1
module tick_gen #(
  parameter int TICK_DIV = 12_500_000
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    tick  = (cnt_q == CNT_MAX);
    cnt_d = cnt_q;
    if (clr || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : tick_gen

// File: rtl/display_scroller.sv
// display_scroller
// Collects an ASCII message one character at a time, then scrolls it
// leftwards across four display digits, followed by four spaces before it
// wraps around.
// Ports:
//   clk, rstn            : clock, synchronous active-low reset
//   char_in/valid/last   : character stream in, valid/ready handshake
//   char_ready           : character accepted this cycle (LOAD, room, no clear)
//   clear                : drop the message, return to LOAD
//   scrolling            : registered, high while in SCROLL
//   display_0..display_3 : ASCII for digits, display_0 leftmost
module display_scroller
  import display_scroller_pkg::*;
#(
  parameter int BUF_DEPTH = 16,
  parameter int TICK_DIV  = 12_500_000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] char_in,
  input  logic       char_valid,
  input  logic       char_last,
  output logic       char_ready,
  input  logic       clear,
  output logic       scrolling,
  output logic [7:0] display_0,
  output logic [7:0] display_1,
  output logic [7:0] display_2,
  output logic [7:0] display_3
);

  // AW addresses the buffer, LW holds 0..BUF_DEPTH, PW holds positions and
  // the intermediate pos+k sums (up to BUF_DEPTH+6).
  localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int LW = $clog2(BUF_DEPTH + 1);
  localparam int PW = $clog2(BUF_DEPTH + 8);

  state_e          state_q, state_d;
  logic [LW-1:0]   len_q, len_d;
  logic [PW-1:0]   pos_q, pos_d;
  logic [PW-1:0]   period_q, period_d;
  logic            scrolling_q;
  logic [7:0]      disp_q [NUM_DIGITS];
  logic [7:0]      disp_d [NUM_DIGITS];

  // Message storage; contents survive reset, only len decides what is shown.
  logic [7:0]      buf_mem [BUF_DEPTH];

  logic            accept;
  logic            tick;

  assign char_ready = (state_q == LOAD) && (len_q < LW'(BUF_DEPTH)) && !clear;
  assign accept     = char_valid && char_ready;

  // Prescaler is held cleared outside SCROLL, so it restarts at each entry.
  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rstn (rstn),
    .clr  (clear || (state_q != SCROLL)),
    .tick (tick)
  );

  assign period_q = PW'(len_q) + PW'(4);
  assign period_d = PW'(len_d) + PW'(4);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    pos_d   = pos_q;
    if (clear) begin
      state_d = LOAD;
      len_d   = '0;
      pos_d   = '0;
    end else begin
      case (state_q)
        LOAD: begin
          pos_d = '0;
          if (accept) begin
            len_d = len_q + 1'b1;
            // A character that fills the buffer is treated as the last one.
            if (char_last || (len_q == LW'(BUF_DEPTH - 1))) begin
              state_d = SCROLL;
            end
          end
        end
        SCROLL: begin
          if (tick) begin
            pos_d = (pos_q == period_q - 1'b1) ? '0 : pos_q + 1'b1;
          end
        end
        default: begin
          state_d = LOAD;
        end
      endcase
    end
  end

  // Buffer write; reset also blocks a simultaneous write.
  always_ff @(posedge clk) begin
    if (rstn && accept) begin
      buf_mem[len_q[AW-1:0]] <= char_in;
    end
  end

  // Digit look-up works on next-state pos/len so the registered digits line
  // up with state, len and pos in the same cycle. The character being
  // written this cycle is not yet in buf_mem, so it is bypassed from char_in.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic [PW-1:0] sum_w;
      logic [PW-1:0] idx_w;
      logic          in_msg_w;
      logic          bypass_w;

      assign sum_w    = pos_d + PW'(gi);
      // pos <= P-1 and gi <= 3 < P, so one conditional subtract is a full mod P.
      assign idx_w    = (sum_w >= period_d) ? (sum_w - period_d) : sum_w;
      assign in_msg_w = (idx_w < PW'(len_d));
      assign bypass_w = accept && (idx_w == PW'(len_q));

      assign disp_d[gi] = !in_msg_w ? ASCII_SPACE :
                          bypass_w  ? char_in     :
                                      buf_mem[idx_w[AW-1:0]];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= LOAD;
      len_q       <= '0;
      pos_q       <= '0;
      scrolling_q <= 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        disp_q[k] <= ASCII_SPACE;
      end
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      pos_q       <= pos_d;
      scrolling_q <= (state_d == SCROLL);
      for (int k = 0; k < NUM_DIGITS; k++) begin
        disp_q[k] <= disp_d[k];
      end
    end
  end

  assign scrolling = scrolling_q;
  assign display_0 = disp_q[0];
  assign display_1 = disp_q[1];
  assign display_2 = disp_q[2];
  assign display_3 = disp_q[3];

endmodule : display_scroller

// File: tb/tb_display_scroller.sv
// tb_display_scroller
// Scoreboard bench: the stimulus process updates a message-level model and
// queues the expected outputs; a negedge monitor pops and compares them.
module tb_display_scroller;

  localparam int BUF_DEPTH = 16;
  localparam int TICK_DIV  = 4;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] char_in;
  logic       char_valid;
  logic       char_last;
  logic       char_ready;
  logic       clear;
  logic       scrolling;
  logic [7:0] display_0, display_1, display_2, display_3;

  always #5 clk = ~clk;

  display_scroller #(
    .BUF_DEPTH (BUF_DEPTH),
    .TICK_DIV  (TICK_DIV)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .char_in    (char_in),
    .char_valid (char_valid),
    .char_last  (char_last),
    .char_ready (char_ready),
    .clear      (clear),
    .scrolling  (scrolling),
    .display_0  (display_0),
    .display_1  (display_1),
    .display_2  (display_2),
    .display_3  (display_3)
  );

  typedef struct packed {
    logic            scroll;
    logic            ready;
    logic [3:0][7:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_cycle  = 0;

  // Reference model: the message itself, whether we are scrolling, and how
  // many cycles have elapsed since scrolling began.
  bit           m_scroll = 0;
  logic [7:0]   m_msg[$];
  int           m_ent = 0;

  function automatic logic [7:0] m_disp(input int k);
    int len, per, pos, i;
    len = m_msg.size();
    if (!m_scroll) return (k < len) ? m_msg[k] : 8'h20;
    per = len + 4;
    pos = (m_ent / TICK_DIV) % per;
    i   = (pos + k) % per;
    return (i < len) ? m_msg[i] : 8'h20;
  endfunction

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, n_cycle, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("scrolling",  {7'd0, scrolling},  {7'd0, e.scroll});
      chk("char_ready", {7'd0, char_ready}, {7'd0, e.ready});
      chk("display_0", display_0, e.d[0]);
      chk("display_1", display_1, e.d[1]);
      chk("display_2", display_2, e.d[2]);
      chk("display_3", display_3, e.d[3]);
    end
  end

  // One clock cycle: drive inputs, queue expectation for the present DUT
  // state under these inputs, then advance the model across the edge.
  task automatic cyc(input bit r, input bit v, input logic [7:0] c,
                     input bit l, input bit clr);
    exp_t e;
    bit   rdy;
    rstn       = r;
    char_valid = v;
    char_in    = c;
    char_last  = l;
    clear      = clr;
    rdy = !m_scroll && (m_msg.size() < BUF_DEPTH) && !clr;
    e.scroll = m_scroll;
    e.ready  = rdy;
    for (int k = 0; k < 4; k++) e.d[k] = m_disp(k);
    exp_q.push_back(e);
    $display("cyc=%0d rstn=%0b valid=%0b char=%h last=%0b clear=%0b exp_ready=%0b exp_disp=%h",
             n_cycle, r, v, c, l, clr, rdy, e.d);
    @(posedge clk);
    #1;
    n_cycle++;
    if (!r || clr) begin
      m_scroll = 0;
      m_msg.delete();
      m_ent = 0;
    end else if (!m_scroll) begin
      if (v && rdy) begin
        m_msg.push_back(c);
        if (l || m_msg.size() == BUF_DEPTH) begin
          m_scroll = 1;
          m_ent    = 0;
        end
      end
    end else begin
      m_ent++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 8'h00, 0, 0);
  endtask

  task automatic load_str(input string s);
    for (int i = 0; i < s.len(); i++) cyc(1, 1, s[i], (i == s.len() - 1), 0);
  endtask

  initial begin
    rstn = 1'b0; char_in = '0; char_valid = 1'b0; char_last = 1'b0; clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, then "HELP" through a full wrap (period 8 -> 32 cycles).
    idle(2);
    load_str("HELP");
    idle(40);
    // Clear mid-scroll together with a character.
    cyc(1, 1, 8'h51, 0, 1);
    idle(2);

    // "A5": period 6, wrap every 24 cycles.
    load_str("A5");
    idle(30);
    cyc(1, 0, 8'h00, 0, 1);
    idle(1);

    // Fill the buffer without char_last; further characters are refused.
    for (int i = 0; i < BUF_DEPTH; i++) cyc(1, 1, 8'h61 + 8'(i), 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 8'h5A, 0, 0);
    idle(10);
    // Reset during SCROLL with clear and char_valid also high.
    cyc(0, 1, 8'h58, 0, 1);
    idle(3);

    // Randomized traffic with backpressure, clears and resets.
    for (int i = 0; i < 2000; i++) begin
      cyc(($urandom_range(0, 499) != 0),
          $urandom_range(0, 1) == 1,
          8'($urandom_range(32, 126)),
          ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 149) == 0));
    end
    idle(2);

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain got=%0d expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_display_scroller
